trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_if.sv | 53 +++++
 rtl/trap_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module   : trap_ctrl_if
// Purpose  : Commit-stage, CSR-port and redirect signals of the trap sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic            trap_ready;
    logic            exc_misaligned;
    logic            exc_illegal;
    logic            exc_ebreak;
    logic            exc_ecall;
    logic            mret;
    logic [XLEN-1:0] trap_pc;
    logic            irq_ext;
    logic [XLEN-1:0] irq_pc;
    logic            ent_trap;
    logic [XLEN-1:0] csr_wr_mepc_mepc;
    logic [XLEN-2:0] csr_wr_mcause_exception_code;
    logic            csr_wr_mcause_interrupt;
    logic [XLEN-3:0] csr_rd_mtvec_base;
    logic [1:0]      csr_rd_mtvec_mode;
    logic [XLEN-1:0] csr_rd_mepc_mepc;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            busy;

    modport slave (
        input  trap_valid, exc_misaligned, exc_illegal, exc_ebreak, exc_ecall,
               mret, trap_pc, irq_ext, irq_pc, csr_rd_mtvec_base,
               csr_rd_mtvec_mode, csr_rd_mepc_mepc, redirect_ready,
        output trap_ready, ent_trap, csr_wr_mepc_mepc,
               csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
               flush, redirect_valid, redirect_pc, busy
    );

    modport master (
        output trap_valid, exc_misaligned, exc_illegal, exc_ebreak, exc_ecall,
               mret, trap_pc, irq_ext, irq_pc, csr_rd_mtvec_base,
               csr_rd_mtvec_mode, csr_rd_mepc_mepc, redirect_ready,
        input  trap_ready, ent_trap, csr_wr_mepc_mepc,
               csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
               flush, redirect_valid, redirect_pc, busy
    );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Trap sequencer: exception/interrupt entry, mret return, redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        REDIR = 2'd2,
        RET   = 2'd3
    } state_t;

    localparam logic [XLEN-2:0] c_CAUSE_MISALIGNED = (XLEN-1)'(0);
    localparam logic [XLEN-2:0] c_CAUSE_ILLEGAL    = (XLEN-1)'(2);
    localparam logic [XLEN-2:0] c_CAUSE_EBREAK     = (XLEN-1)'(3);
    localparam logic [XLEN-2:0] c_CAUSE_M_ECALL    = (XLEN-1)'(11);
    localparam logic [XLEN-2:0] c_CAUSE_M_EXT_IRQ  = (XLEN-1)'(11);

    state_t          state_q, state_d;
    logic            irq_q, irq_d;
    logic [XLEN-2:0] code_q, code_d;
    logic            intr_q, intr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic            w_exc_any;
    logic [XLEN-2:0] w_exc_code;
    logic            w_take;
    logic [XLEN-1:0] w_tvec;
    logic [XLEN-1:0] w_vec_target;
    logic            w_unused;

    assign w_exc_any = bus.trap_valid & (bus.exc_misaligned | bus.exc_illegal |
                                         bus.exc_ebreak | bus.exc_ecall);

    always_comb begin
        w_exc_code = c_CAUSE_M_ECALL;
        if (bus.exc_misaligned)   w_exc_code = c_CAUSE_MISALIGNED;
        else if (bus.exc_illegal) w_exc_code = c_CAUSE_ILLEGAL;
        else if (bus.exc_ebreak)  w_exc_code = c_CAUSE_EBREAK;
    end

    // Only interrupts vector; mode 2/3 fall back to direct.
    assign w_tvec       = {bus.csr_rd_mtvec_base, 2'b00};
    assign w_vec_target = (bus.csr_rd_mtvec_mode == 2'b01 && intr_q)
                        ? w_tvec + {code_q[XLEN-3:0], 2'b00}
                        : w_tvec;

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q | bus.irq_ext;
        code_d  = code_q;
        intr_d  = intr_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        w_take  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_exc_any) begin
                    state_d = ENTER;
                    code_d  = w_exc_code;
                    intr_d  = 1'b0;
                    pc_d    = {bus.trap_pc[XLEN-1:2], 2'b00};
                    w_take  = 1'b1;
                end else if (bus.trap_valid && bus.mret) begin
                    state_d = RET;
                    rpc_d   = bus.csr_rd_mepc_mepc;
                    w_take  = 1'b1;
                end else if (!bus.trap_valid && irq_q) begin
                    state_d = ENTER;
                    code_d  = c_CAUSE_M_EXT_IRQ;
                    intr_d  = 1'b1;
                    pc_d    = {bus.irq_pc[XLEN-1:2], 2'b00};
                    irq_d   = 1'b0;
                    w_take  = 1'b1;
                end
            end
            ENTER: begin
                state_d = REDIR;
                rpc_d   = w_vec_target;
            end
            REDIR, RET: begin
                if (bus.redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            code_q  <= '0;
            intr_q  <= 1'b0;
            pc_q    <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            code_q  <= code_d;
            intr_q  <= intr_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
        end
    end

    assign bus.trap_ready     = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.flush          = bus.busy | w_take;
    assign bus.ent_trap       = (state_q == ENTER);
    assign bus.redirect_valid = (state_q == REDIR) || (state_q == RET);
    assign bus.redirect_pc    = bus.redirect_valid ? rpc_q : '0;

    assign bus.csr_wr_mepc_mepc             = bus.ent_trap ? pc_q : '0;
    assign bus.csr_wr_mcause_exception_code = bus.ent_trap ? code_q : '0;
    assign bus.csr_wr_mcause_interrupt      = bus.ent_trap & intr_q;

    // Low PC bits are always forced to zero on capture.
    assign w_unused = ^{bus.trap_pc[1:0], bus.irq_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed bench for trap_ctrl with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   armed = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    trap_ctrl_if #(.XLEN(XLEN)) bus ();

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the event in flight by kind and age (cycles since accept).
    int              m_kind = 0;   // 0 none, 1 trap entry, 2 mret
    int              m_age = 0;
    logic            m_irq = 1'b0;
    logic [XLEN-1:0] m_pc = '0;
    logic [XLEN-1:0] m_target = '0;
    logic [XLEN-2:0] m_code = '0;
    logic            m_int = 1'b0;

    function automatic logic [XLEN-2:0] exc_code(input logic mis, ill, ebr);
        if (mis) return 0;
        if (ill) return 2;
        if (ebr) return 3;
        return 11;
    endfunction

    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-3:0] base,
            input logic [1:0] mode, input logic [XLEN-2:0] code, input logic intr);
        logic [XLEN-1:0] tvec;
        tvec = XLEN'(base) * 4;
        if (mode == 2'd1 && intr) return tvec + XLEN'(code) * 4;
        return tvec;
    endfunction

    function automatic bit model_rv();
        return (m_kind == 1 && m_age >= 2) || (m_kind == 2 && m_age >= 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_kind <= 0;
            m_age  <= 0;
            m_irq  <= 1'b0;
        end else if (m_kind == 0) begin
            m_irq <= m_irq | bus.irq_ext;
            if (bus.trap_valid && (bus.exc_misaligned || bus.exc_illegal ||
                                   bus.exc_ebreak || bus.exc_ecall)) begin
                m_kind <= 1;
                m_age  <= 1;
                m_code <= exc_code(bus.exc_misaligned, bus.exc_illegal, bus.exc_ebreak);
                m_int  <= 1'b0;
                m_pc   <= bus.trap_pc & ~32'h3;
            end else if (bus.trap_valid && bus.mret) begin
                m_kind   <= 2;
                m_age    <= 1;
                m_target <= bus.csr_rd_mepc_mepc;
            end else if (!bus.trap_valid && m_irq) begin
                m_kind <= 1;
                m_age  <= 1;
                m_code <= 11;
                m_int  <= 1'b1;
                m_pc   <= bus.irq_pc & ~32'h3;
                m_irq  <= 1'b0;
            end
        end else begin
            m_irq <= m_irq | bus.irq_ext;
            m_age <= m_age + 1;
            if (m_kind == 1 && m_age == 1)
                m_target <= trap_target(bus.csr_rd_mtvec_base, bus.csr_rd_mtvec_mode, m_code, m_int);
            if (model_rv() && bus.redirect_ready) m_kind <= 0;
        end
    end

    always @(negedge clk) begin
        bit idle, ev, e_ent, e_rv;
        if (armed) begin
            idle  = (m_kind == 0);
            ev    = idle && ((bus.trap_valid && (bus.exc_misaligned || bus.exc_illegal ||
                              bus.exc_ebreak || bus.exc_ecall || bus.mret)) ||
                             (!bus.trap_valid && m_irq));
            e_ent = (m_kind == 1 && m_age == 1);
            e_rv  = model_rv();
            chk("trap_ready", 64'(bus.trap_ready), 64'(idle));
            chk("busy", 64'(bus.busy), 64'(!idle));
            chk("flush", 64'(bus.flush), 64'(!idle || ev));
            chk("ent_trap", 64'(bus.ent_trap), 64'(e_ent));
            chk("mepc_wr", 64'(bus.csr_wr_mepc_mepc), e_ent ? 64'(m_pc) : 64'd0);
            chk("mcause_code", 64'(bus.csr_wr_mcause_exception_code), e_ent ? 64'(m_code) : 64'd0);
            chk("mcause_int", 64'(bus.csr_wr_mcause_interrupt), 64'(e_ent && m_int));
            chk("redirect_valid", 64'(bus.redirect_valid), 64'(e_rv));
            chk("redirect_pc", 64'(bus.redirect_pc), e_rv ? 64'(m_target) : 64'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_ev();
        bus.trap_valid     = 1'b0;
        bus.exc_misaligned = 1'b0;
        bus.exc_illegal    = 1'b0;
        bus.exc_ebreak     = 1'b0;
        bus.exc_ecall      = 1'b0;
        bus.mret           = 1'b0;
        bus.irq_ext        = 1'b0;
    endtask

    initial begin
        clr_ev();
        bus.trap_pc           = '0;
        bus.irq_pc            = '0;
        bus.csr_rd_mtvec_base = 30'h2000_0040;   // mtvec 0x8000_0100, direct
        bus.csr_rd_mtvec_mode = 2'd0;
        bus.csr_rd_mepc_mepc  = 32'h8000_0040;
        bus.redirect_ready    = 1'b1;
        tick(2);
        rst   = 1'b0;
        armed = 1'b1;
        #1;
        chk("lit_reset_ready", 64'(bus.trap_ready), 64'd1);
        chk("lit_reset_flush", 64'(bus.flush), 64'd0);

        // Exception entry: ecall, direct mtvec
        bus.trap_valid = 1'b1; bus.exc_ecall = 1'b1; bus.trap_pc = 32'h8000_0024;
        #1 chk("lit_accept_flush", 64'(bus.flush), 64'd1);
        tick(1); clr_ev();
        #1;
        chk("lit_ent_trap", 64'(bus.ent_trap), 64'd1);
        chk("lit_ecall_mepc", 64'(bus.csr_wr_mepc_mepc), 64'h8000_0024);
        chk("lit_ecall_code", 64'(bus.csr_wr_mcause_exception_code), 64'h0000_000B);
        tick(1); #1;
        chk("lit_ecall_rv", 64'(bus.redirect_valid), 64'd1);
        chk("lit_ecall_rpc", 64'(bus.redirect_pc), 64'h8000_0100);
        tick(1);

        // Cause priority, exception beats mret
        bus.trap_valid = 1'b1; bus.exc_illegal = 1'b1; bus.exc_ebreak = 1'b1;
        bus.exc_ecall = 1'b1; bus.mret = 1'b1;
        tick(1); clr_ev();
        #1 chk("lit_prio_code2", 64'(bus.csr_wr_mcause_exception_code), 64'd2);
        tick(2);
        bus.trap_valid = 1'b1; bus.exc_misaligned = 1'b1; bus.exc_illegal = 1'b1;
        bus.trap_pc = 32'h8000_0033;
        tick(1); clr_ev();
        #1;
        chk("lit_prio_code0", 64'(bus.csr_wr_mcause_exception_code), 64'd0);
        chk("lit_prio_mepc", 64'(bus.csr_wr_mepc_mepc), 64'h8000_0030);
        tick(2);

        // mret returns to mepc one cycle after accept
        bus.trap_valid = 1'b1; bus.mret = 1'b1;
        tick(1); clr_ev();
        #1;
        chk("lit_mret_rpc", 64'(bus.redirect_pc), 64'h8000_0040);
        chk("lit_mret_no_ent", 64'(bus.ent_trap), 64'd0);
        tick(1);

        // Vectored interrupt
        bus.csr_rd_mtvec_base = 30'h2000_0000; bus.csr_rd_mtvec_mode = 2'd1;
        bus.irq_ext = 1'b1; bus.irq_pc = 32'h8000_0012;
        tick(1); clr_ev();
        tick(1);
        #1;
        chk("lit_irq_int", 64'(bus.csr_wr_mcause_interrupt), 64'd1);
        chk("lit_irq_code", 64'(bus.csr_wr_mcause_exception_code), 64'h0000_000B);
        chk("lit_irq_mepc", 64'(bus.csr_wr_mepc_mepc), 64'h8000_0010);
        tick(1); #1;
        chk("lit_irq_rpc", 64'(bus.redirect_pc), 64'h8000_002C);
        tick(1);
        bus.trap_valid = 1'b1; bus.exc_ecall = 1'b1;
        tick(1); clr_ev();
        tick(1); #1;
        chk("lit_vec_exc_rpc", 64'(bus.redirect_pc), 64'h8000_0000);
        tick(1);

        // Backpressure with an interrupt arriving while busy
        bus.redirect_ready = 1'b0;
        bus.trap_valid = 1'b1; bus.exc_ebreak = 1'b1; bus.trap_pc = 32'h8000_0050;
        tick(1); clr_ev();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            bus.irq_ext = (i == 1);
            #1;
            chk("lit_bp_rv", 64'(bus.redirect_valid), 64'd1);
            chk("lit_bp_ready", 64'(bus.trap_ready), 64'd0);
            tick(1);
        end
        bus.irq_ext = 1'b0;
        bus.redirect_ready = 1'b1;
        tick(1); #1;
        chk("lit_bp_irq_taken", 64'(bus.flush), 64'd1);
        tick(1); #1;
        chk("lit_bp_irq_ent", 64'(bus.csr_wr_mcause_interrupt), 64'd1);
        tick(2);

        // Reset during ENTER with a pending interrupt
        bus.trap_valid = 1'b1; bus.exc_ecall = 1'b1;
        tick(1); clr_ev();
        bus.irq_ext = 1'b1; rst = 1'b1;
        #1 chk("lit_rst_enter_pre", 64'(bus.ent_trap), 64'd1);
        tick(1);
        rst = 1'b0; bus.irq_ext = 1'b0;
        #1;
        chk("lit_rst_enter_ready", 64'(bus.trap_ready), 64'd1);
        chk("lit_rst_enter_flush", 64'(bus.flush), 64'd0);
        tick(4);

        // Reset during REDIR
        bus.redirect_ready = 1'b0;
        bus.trap_valid = 1'b1; bus.exc_illegal = 1'b1;
        tick(1); clr_ev();
        tick(1);
        rst = 1'b1;
        #1 chk("lit_rst_redir_pre", 64'(bus.redirect_valid), 64'd1);
        tick(1);
        rst = 1'b0;
        #1;
        chk("lit_rst_redir_rv", 64'(bus.redirect_valid), 64'd0);
        chk("lit_rst_redir_pc", 64'(bus.redirect_pc), 64'd0);
        tick(4);
        bus.redirect_ready = 1'b1;
        tick(2);

        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
